// File: rtl/capture_sched_pkg.sv
// Shared types and constants for the capture scheduler.
// Latency: none, declarations only.
// Backpressure: not applicable.
package capture_sched_pkg;

  // Capture FSM: IDLE waits for a tick, HOLD presents a captured word downstream.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Width and saturation value of the lost-tick counter.
  localparam int              OVR_W   = 8;
  localparam logic [OVR_W-1:0] OVR_MAX = 8'hFF;

  // Round-robin pick between two requesters: a lone requester wins,
  // under contention the one that was not granted last time wins.
  function automatic logic rr_pick(input logic [1:0] valid, input logic last);
    logic pick;
    if (valid == 2'b11) begin
      pick = ~last;
    end else begin
      pick = valid[1];
    end
    return pick;
  endfunction

endpackage

// File: rtl/capture_tick_gen.sv
// Free-running modulo-PERIOD counter producing a one-cycle sampling tick.
// Latency: tick is combinational from the counter state and run_i.
// Backpressure: none; the counter never stalls, run_i=0 clears and holds it.
module capture_tick_gen #(
  parameter int PERIOD = 10,
  parameter int CNT_W  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic tick_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic             at_last;

  assign at_last = (cnt == CNT_LAST);

  // Tick is suppressed while in reset so no grant can fire in a reset cycle.
  assign tick_o = at_last & run_i & ~rst;

  // Count while running, wrap at PERIOD-1, park at zero when stopped.
  always_ff @(posedge clk) begin
    if (rst || !run_i) begin
      cnt <= '0;
    end else if (at_last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/capture_scheduler.sv
// Periodic round-robin capture of two requesters into one output register.
// Latency: out_valid_o rises one cycle after the tick/req_ready grant cycle.
// Backpressure: out_ready_i low holds the word; ticks lost meanwhile are counted
//   in overrun_o when CAPTURE_SCHED_OVERRUN_EN is defined, else overrun_o is 0.
module capture_scheduler
  import capture_sched_pkg::*;
#(
  parameter int DW     = 32,
  parameter int PERIOD = 10,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_i,
  input  logic [1:0]       req_valid_i,
  input  logic [DW-1:0]    req_data0_i,
  input  logic [DW-1:0]    req_data1_i,
  output logic [1:0]       req_ready_o,
  output logic             tick_o,
  output logic             out_valid_o,
  output logic [DW-1:0]    out_data_o,
  output logic             out_src_o,
  input  logic             out_ready_i,
  output logic [OVR_W-1:0] overrun_o
);

  state_t state;
  state_t state_nxt;
  logic   tick;
  logic   any_req;
  logic   winner;
  logic   grant;
  logic   last_grant;

  capture_tick_gen #(
    .PERIOD (PERIOD),
    .CNT_W  (CNT_W)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .run_i  (run_i),
    .tick_o (tick)
  );

  assign tick_o  = tick;
  assign any_req = |req_valid_i;
  assign winner  = rr_pick(req_valid_i, last_grant);

  // The capture register is full exactly while the FSM is in HOLD.
  assign out_valid_o = (state == HOLD);

  // Next state and the single-cycle grant; ready is only ever raised in the
  // IDLE tick cycle, which also keeps it low through reset (tick is gated).
  always_comb begin
    state_nxt   = state;
    grant       = 1'b0;
    req_ready_o = 2'b00;
    case (state)
      IDLE: begin
        if (tick && any_req) begin
          grant               = 1'b1;
          req_ready_o[winner] = 1'b1;
          state_nxt           = HOLD;
        end
      end
      HOLD: begin
        if (out_ready_i) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture register: loads the winner's word on a grant, otherwise holds,
  // so the last word stays visible after the downstream accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_o <= '0;
      out_src_o  <= 1'b0;
    end else if (grant) begin
      out_data_o <= winner ? req_data1_i : req_data0_i;
      out_src_o  <= winner;
    end
  end

  // Round-robin history; resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (grant) begin
      last_grant <= winner;
    end
  end

`ifdef CAPTURE_SCHED_OVERRUN_EN
  logic [OVR_W-1:0] overrun;

  assign overrun_o = overrun;

  // Count ticks that find the register busy with a request waiting, including
  // the tick that coincides with the accept, since no capture happens then.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= '0;
    end else if (tick && (state == HOLD) && any_req && (overrun != OVR_MAX)) begin
      overrun <= overrun + OVR_W'(1);
    end
  end
`else
  assign overrun_o = '0;
`endif

endmodule

// File: tb/tb_capture_scheduler.sv
// Randomized and directed bench for capture_scheduler against a cycle model.
// Latency: model predicts outputs each cycle, sampled on the falling edge.
// Backpressure: downstream ready and requester valids are driven by the bench.
module tb_capture_scheduler;

  localparam int DW     = 32;
  localparam int PERIOD = 10;
  localparam int CNT_W  = 4;
`ifdef CAPTURE_SCHED_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic [1:0]    rv;
  logic [DW-1:0] d0;
  logic [DW-1:0] d1;
  logic [1:0]    rdy;
  logic          tick;
  logic          ov;
  logic [DW-1:0] od;
  logic          os;
  logic          out_ready;
  logic [7:0]    ovr;

  capture_scheduler #(
    .DW     (DW),
    .PERIOD (PERIOD),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run_i       (run),
    .req_valid_i (rv),
    .req_data0_i (d0),
    .req_data1_i (d1),
    .req_ready_o (rdy),
    .tick_o      (tick),
    .out_valid_o (ov),
    .out_data_o  (od),
    .out_src_o   (os),
    .out_ready_i (out_ready),
    .overrun_o   (ovr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Behavioural model: position within the period, whether a word is held,
  // which word/source, who won last, and how many ticks were lost.
  int            m_cnt;
  bit            m_busy;
  logic [DW-1:0] m_data;
  bit            m_src;
  bit            m_last;
  int            m_ovr;

  bit            rand_mode = 1'b0;
  bit            obs_tick;
  logic [1:0]    obs_rdy;
  bit            prev_ov = 1'b0;
  bit            src_log[$];
  logic [DW-1:0] data_log[$];

  task automatic model_reset();
    m_cnt  = 0;
    m_busy = 1'b0;
    m_data = '0;
    m_src  = 1'b0;
    m_last = 1'b1;
    m_ovr  = 0;
  endtask

  // After a requester is accepted it re-presents with fresh data.
  task automatic present_next(input int i);
    bit v;
    v = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    rv[i] = v;
    if (i == 0) d0 = $urandom;
    else        d1 = $urandom;
  endtask

  task automatic step();
    bit         et;
    bit         g;
    bit         w;
    logic [1:0] er;
    @(negedge clk);
    et = !rst && run && (m_cnt == PERIOD - 1);
    g  = et && !m_busy && (rv != 2'b00);
    w  = (rv == 2'b11) ? !m_last : rv[1];
    er = g ? (w ? 2'b10 : 2'b01) : 2'b00;
    chk("tick", tick, et);
    chk("req_ready", rdy, er);
    chk("out_valid", ov, m_busy);
    chk("out_data", od, m_data);
    chk("out_src", os, m_src);
    chk("overrun", ovr, OVR_EN ? m_ovr : 0);
    obs_tick = tick;
    obs_rdy  = rdy;
    if (ov && !prev_ov) begin
      src_log.push_back(os);
      data_log.push_back(od);
    end
    prev_ov = ov;
    if (rst) begin
      model_reset();
    end else begin
      if (m_busy && et && (rv != 2'b00) && (m_ovr < 255)) m_ovr++;
      if (g) begin
        m_busy = 1'b1;
        m_data = w ? d1 : d0;
        m_src  = w;
        m_last = w;
      end else if (m_busy && out_ready) begin
        m_busy = 1'b0;
      end
      m_cnt = run ? (m_cnt + 1) % PERIOD : 0;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) if (er[i]) present_next(i);
  endtask

  task automatic reset_one();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic first_tick_check(input string tag);
    int ft;
    ft = -1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (obs_tick && ft < 0) ft = k;
    end
    chk(tag, ft, PERIOD - 1);
  endtask

  initial begin
    int guard;
    int nt;
    int nr;
    rst = 1'b1; run = 1'b1; rv = 2'b01; d0 = 32'hA5A5_0001; d1 = '0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    model_reset();

    // Single requester: reset state, then first tick at cnt==9 and capture.
    step();
    rst = 1'b0;
    src_log.delete(); data_log.delete();
    first_tick_check("A_first_tick");
    chk("A_cap_count", data_log.size(), 1);
    if (data_log.size() > 0) begin
      chk("A_cap_data", data_log[0], 32'hA5A5_0001);
      chk("A_cap_src", src_log[0], 0);
    end

    // Contention: both valid across four ticks must alternate 0,1,0,1.
    reset_one();
    rv = 2'b11; d0 = $urandom; d1 = $urandom; out_ready = 1'b1;
    src_log.delete(); data_log.delete();
    repeat (4 * PERIOD + 2) step();
    chk("B_cap_count", src_log.size(), 4);
    for (int j = 0; j < 4; j++) if (j < src_log.size()) chk("B_src_order", src_log[j], j % 2);

    // Backpressure: hold the first capture for 35 cycles.
    reset_one();
    rv = 2'b01; d0 = 32'hC0DE_0001; d1 = '0; out_ready = 1'b1;
    guard = 0;
    while (!m_busy && guard < 20) begin step(); guard++; end
    out_ready = 1'b0;
    repeat (35) step();
    chk("C_overrun", ovr, OVR_EN ? 3 : 0);
    chk("C_valid", ov, 1);
    chk("C_data", od, 32'hC0DE_0001);

    // Accept coinciding with a tick: lost tick counted, capture on next tick.
    guard = 0;
    while (m_cnt != PERIOD - 1 && guard < PERIOD) begin step(); guard++; end
    out_ready = 1'b1;
    step();
    chk("D_overrun", ovr, OVR_EN ? 4 : 0);
    chk("D_idle", ov, 0);
    out_ready = 1'b0;
    src_log.delete(); data_log.delete();
    repeat (PERIOD + 1) step();
    chk("D_next_capture", src_log.size(), 1);

    // Reset during HOLD clears everything; first tick again 9 cycles later.
    reset_one();
    chk("E_valid", ov, 0);
    chk("E_data", od, 0);
    chk("E_overrun", ovr, 0);
    out_ready = 1'b1;
    first_tick_check("E_first_tick");

    // run_i low: no tick and no ready for 20 cycles.
    run = 1'b0; rv = 2'b11;
    nt = 0; nr = 0;
    repeat (20) begin
      step();
      if (obs_tick) nt++;
      if (obs_rdy != 2'b00) nr++;
    end
    chk("F_ticks", nt, 0);
    chk("F_readys", nr, 0);

    // Random traffic against the model.
    rand_mode = 1'b1;
    repeat (3000) begin
      run       = ($urandom_range(0, 19) != 0);
      rst       = ($urandom_range(0, 299) == 0);
      out_ready = 1'($urandom_range(0, 1));
      for (int i = 0; i < 2; i++) begin
        if (!rv[i] && $urandom_range(0, 3) == 0) begin
          rv[i] = 1'b1;
          if (i == 0) d0 = $urandom;
          else        d1 = $urandom;
        end
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
